modport_ram: RTL and testbench
==============================

MODPORT_RAM -- requirements
Module: modport_ram

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter ADDR_W, default 5: address width in bits.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W): number of memory words.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-005 clk  input  1: clock; all state updates on the rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 write_en  input  1: write strobe, sampled at the rising clk edge.
REQ-008 read_en  input  1: read strobe, sampled at the rising clk edge.
REQ-009 addr  input  ADDR_W: word address shared by read and write.
REQ-010 data_in  input  DATA_W: write data.
REQ-011 data_out  output  DATA_W: registered read data.

Function
REQ-012 The block SHALL implement a single-port RAM of DEPTH x DATA_W words.
REQ-013 With write_en=1 at a rising edge, mem[addr] SHALL take data_in at that edge.
REQ-014 With read_en=1 and write_en=0 at a rising edge, data_out SHALL take mem[addr] at that edge (1-cycle latency).
REQ-015 With read_en=0 at a rising edge, data_out SHALL hold its previous value.
REQ-016 With write_en=1 and read_en=1 together, the write SHALL occur, and data_out SHALL take the pre-write contents of mem[addr] (read-before-write).
REQ-017 With write_en=0 and read_en=0, memory contents SHALL be unchanged.
REQ-018 Every addr value 0..DEPTH-1 SHALL be valid; no out-of-range case exists when DEPTH = 2**ADDR_W.
REQ-019 data_out SHALL be driven only from a register, with no combinational path from inputs.
REQ-020 Consecutive cycles SHALL be independent; back-to-back reads and writes are legal every cycle with no handshake or stall.

Reset
REQ-021 While rst=1 at a rising edge, data_out SHALL become 0.
REQ-022 While rst=1 at a rising edge, every memory word SHALL become 0.
REQ-023 rst SHALL override write_en and read_en in the same cycle.
REQ-024 Reset asserted mid-sequence SHALL discard any pending access; the first access after rst deasserts SHALL be honoured normally.

Structure
REQ-025 DATA_W, ADDR_W and DEPTH defaults SHALL be defined in a shared package, ram_pkg, which the block imports.
REQ-026 The block SHALL be a single module with no sub-modules; the memory is an unpacked array of DATA_W-bit registers.
REQ-027 The port list SHALL match the signal names clk, rst, data_in, data_out, write_en, read_en and addr, so the block binds to the existing bench interface.

Verification
REQ-028 Reset check: rst=1 for 2 cycles, then read addr 0..31 -> data_out=0x00 one cycle after each read.
REQ-029 Write then read: write 0xA5 to addr 5; next cycle read addr 5 -> data_out=0xA5 on the following edge.
REQ-030 Full sweep: write addr*3 to addr 0..31, then read all -> each data_out=addr*3 (8-bit truncated); covers addr 0 and addr 31.
REQ-031 Simultaneous access: mem[7]=0x11; write 0x22 to addr 7 with read_en=1 -> data_out=0x11; next read of addr 7 -> 0x22.
REQ-032 Hold: read addr 3 (mem[3]=0x3C), then 4 idle cycles with write traffic to addr 4 -> data_out stays 0x3C.
REQ-033 Mid-operation reset: write 0xFF to addr 9, then assert rst for 1 cycle, then read addr 9 -> data_out=0x00.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared defaults for the single-port RAM block.
package ram_pkg;

    // Default word width in bits.
    localparam int unsigned RAM_DATA_W = 8;
    // Default address width in bits.
    localparam int unsigned RAM_ADDR_W = 5;
    // Default number of words; fully decodes the address space.
    localparam int unsigned RAM_DEPTH  = 2 ** RAM_ADDR_W;

endpackage : ram_pkg

// File: rtl/modport_ram.sv
// Single-port RAM, DEPTH x DATA_W, with registered read data and read-before-write
// behaviour when a read and a write hit the same cycle. Synchronous reset clears
// both the output register and every memory word.
module modport_ram
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_q;

    // Memory array and read register; the read samples mem_q before this edge's
    // write lands, which gives read-before-write on a simultaneous access.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            if (write_en) begin
                mem_q[addr] <= data_in;
            end
            if (read_en) begin
                data_out_q <= mem_q[addr];
            end
        end
    end

    assign data_out = data_out_q;

endmodule : modport_ram

// File: tb/tb_modport_ram.sv
// Self-checking bench for modport_ram: directed scenarios plus random traffic,
// compared against a plain array model of the RAM.
module tb_modport_ram;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned DP = 32;

    logic          clk;
    logic          rst;
    logic          write_en;
    logic          read_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    logic [DW-1:0] ref_mem [DP];
    logic [DW-1:0] ref_out;

    int errors;
    int checks;

    modport_ram #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (DP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .write_en(write_en),
        .read_en (read_en),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge,
    // compare just after it.
    task automatic cycle(input logic r, input logic we, input logic re,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst      = r;
        write_en = we;
        read_en  = re;
        addr     = a;
        data_in  = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DP; i++) ref_mem[i] = '0;
            ref_out = '0;
        end else begin
            if (re) ref_out = ref_mem[a];
            if (we) ref_mem[a] = d;
        end
        #1;
        check("model", data_out, ref_out);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        addr     = '0;
        data_in  = '0;
        ref_out  = '0;

        // Reset for two cycles, then every word reads back as zero.
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 5'd1, 8'hEE);
        check("reset_out", data_out, 8'h00);
        for (int a = 0; a < DP; a++) begin
            cycle(1'b0, 1'b0, 1'b1, AW'(a), 8'h00);
            check("reset_mem", data_out, 8'h00);
        end

        // Write then read.
        cycle(1'b0, 1'b1, 1'b0, 5'd5, 8'hA5);
        cycle(1'b0, 1'b0, 1'b1, 5'd5, 8'h00);
        check("wr_rd_a5", data_out, 8'hA5);

        // Full sweep of addr*3.
        for (int a = 0; a < DP; a++) cycle(1'b0, 1'b1, 1'b0, AW'(a), DW'(a * 3));
        for (int a = 0; a < DP; a++) begin
            cycle(1'b0, 1'b0, 1'b1, AW'(a), 8'h00);
            check("sweep", data_out, DW'(a * 3));
        end

        // Simultaneous access returns the old contents.
        cycle(1'b0, 1'b1, 1'b0, 5'd7, 8'h11);
        cycle(1'b0, 1'b1, 1'b1, 5'd7, 8'h22);
        check("rbw_old", data_out, 8'h11);
        cycle(1'b0, 1'b0, 1'b1, 5'd7, 8'h00);
        check("rbw_new", data_out, 8'h22);

        // Hold while writes go elsewhere.
        cycle(1'b0, 1'b1, 1'b0, 5'd3, 8'h3C);
        cycle(1'b0, 1'b0, 1'b1, 5'd3, 8'h00);
        check("hold_rd", data_out, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 5'd4, DW'(8'h40 + i));
            check("hold", data_out, 8'h3C);
        end
        cycle(1'b0, 1'b0, 1'b1, 5'd4, 8'h00);
        check("hold_wr4", data_out, 8'h43);

        // Mid-operation reset wipes the earlier write.
        cycle(1'b0, 1'b1, 1'b0, 5'd9, 8'hFF);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        check("midrst_out", data_out, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 5'd9, 8'h00);
        check("midrst_mem", data_out, 8'h00);

        // Reset overrides a write in the same cycle; next access is honoured.
        cycle(1'b0, 1'b1, 1'b0, 5'd2, 8'h5A);
        cycle(1'b1, 1'b1, 1'b1, 5'd2, 8'h77);
        cycle(1'b0, 1'b1, 1'b1, 5'd2, 8'h66);
        check("rst_override", data_out, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 5'd2, 8'h00);
        check("post_rst_wr", data_out, 8'h66);
        cycle(1'b0, 1'b1, 1'b0, 5'd31, 8'hC3);
        cycle(1'b0, 1'b0, 1'b1, 5'd31, 8'h00);
        check("top_addr", data_out, 8'hC3);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                  AW'($urandom), DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_modport_ram
